// File: rtl/bcd_to_bin_seq_pkg.sv
// rtl/bcd_to_bin_seq_pkg.sv - shared types, constants and width helper for the BCD-to-binary converter
package bcd_pkg;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

  // ceil(log2(10^digits)): the binary width needed for the largest DIGITS-digit decimal value
  function automatic int bin_width(input int digits);
    longint p;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    return $clog2(p);
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// rtl/bcd_to_bin_seq_if.sv - BCD word input and binary result output handshakes
interface bcd_to_bin_seq_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
  logic [4*DIGITS-1:0] bcd_in;
  logic                in_valid;
  logic                in_ready;
  logic [BIN_W-1:0]    bin_out;
  logic                out_valid;
  logic                out_ready;
  logic                err;

  modport master (
    output bcd_in, in_valid, out_ready,
    input  in_ready, bin_out, out_valid, err
  );

  modport slave (
    input  bcd_in, in_valid, out_ready,
    output in_ready, bin_out, out_valid, err
  );
endinterface

// File: rtl/bcd_to_bin_seq_digit_mac.sv
// rtl/bcd_to_bin_seq_digit_mac.sv - one decimal step: acc*10 + digit, modulo 2^BIN_W
module bcd_digit_mac
  import bcd_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic [BIN_W-1:0] acc,
  input  logic [3:0]       digit,
  output logic [BIN_W-1:0] out,
  output logic             digit_bad
);

  // Bits above BIN_W never reach the result, so the sum is formed directly at BIN_W.
  assign out       = (acc << 3) + (acc << 1) + BIN_W'(digit);
  assign digit_bad = (digit > DIGIT_MAX);

endmodule

// File: rtl/bcd_to_bin_seq.sv
// rtl/bcd_to_bin_seq.sv - iterative packed-BCD to binary converter, MSD first; BCD_TO_BIN_ERR_CHECK_EN enables invalid-digit flagging
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input logic             clk,
  input logic             rst_n,
  bcd_to_bin_seq_if.slave bus
);

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

`ifdef BCD_TO_BIN_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  if (BIN_W != bin_width(DIGITS)) begin : g_bad_bin_w
    $error("bcd_to_bin_seq: BIN_W does not match DIGITS");
  end

  state_t              state;
  state_t              state_next;
  logic [4*DIGITS-1:0] sr;
  logic [BIN_W-1:0]    acc;
  logic [BIN_W-1:0]    bin_r;
  logic [CNT_W-1:0]    cnt;
  logic                err_r;
  logic                err_next;
  logic [BIN_W-1:0]    mac_out;
  logic                digit_bad;
  logic                in_ready_c;
  logic                out_valid_c;
  logic                conv_last;

  bcd_digit_mac #(.BIN_W(BIN_W)) u_mac (
    .acc       (acc),
    .digit     (sr[4*DIGITS-1 -: 4]),
    .out       (mac_out),
    .digit_bad (digit_bad)
  );

  assign conv_last = (cnt == CNT_LAST);
  assign err_next  = err_r | digit_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_next = CONV;
      end
      CONV: begin
        if (conv_last) state_next = HOLD;
      end
      HOLD: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr    <= '0;
      acc   <= '0;
      bin_r <= '0;
      cnt   <= '0;
      err_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sr    <= bus.bcd_in;
            acc   <= '0;
            cnt   <= '0;
            err_r <= 1'b0;
          end
        end
        CONV: begin
          acc   <= mac_out;
          sr    <= sr << 4;
          cnt   <= cnt + 1'b1;
          err_r <= err_next;
          // The published result changes only here, so it survives HOLD and the following IDLE.
          if (conv_last) bin_r <= (ERR_EN && err_next) ? '0 : mac_out;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.bin_out   = bin_r;
  assign bus.err       = ERR_EN ? err_r : 1'b0;

endmodule
